muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multi-cycle multiply/divide unit for the pipelined CPU's HI/LO datapath.
//   The combinational ALU serves single-cycle ops. This block accepts MULT/MULTU/DIV/DIVU
//   operands from the EX stage, runs a radix-2 shift-add or restoring-divide loop, and
//   returns a 2*WIDTH result in hi/lo. busy is the pipeline stall request.
// PARAMETERS
//   WIDTH  32  operand width; one iteration per bit, so latency = WIDTH cycles
// PORTS
//   clock   in   1      rising-edge clock
//   resetn  in   1      asynchronous, active-low reset
//   start   in   1      launch request; sampled only in IDLE or DONE
//   cancel  in   1      pipeline flush; aborts a running op
//   op      in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//   a       in   WIDTH  multiplicand / dividend
//   b       in   WIDTH  multiplier / divisor
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse: hi/lo updated this cycle
//   dz      out  1      last completed op was a divide by zero; held until next completion
//   hi      out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
//   lo      out  WIDTH  MUL: product[W-1:0];  DIV: quotient
// BEHAVIOUR
//   Reset: resetn low clears state, counter, operand regs, busy, done, dz, hi and lo to 0
//     at once, without waiting for a clock edge. This also applies mid-RUN.
//   FSM states: IDLE, RUN, DONE.
//     IDLE -> RUN   on an edge with start=1 and cancel=0. op, |a| and |b| are latched;
//                   the result sign is latched; count=WIDTH.
//     RUN  -> RUN   each edge does one iteration and decrements count. start is ignored.
//     RUN  -> DONE  on the edge where count==1. The sign-fixed result is written to hi/lo.
//     RUN  -> IDLE  on any edge with cancel=1. hi, lo and dz are unchanged; no done pulse.
//     DONE -> RUN   if start=1 and cancel=0 (back-to-back ops allowed); otherwise -> IDLE.
//   cancel has priority over start in every state.
//   Timing: start is sampled at edge e0. busy=1 from e0 until eWIDTH.
//     done=1 for exactly one cycle after eWIDTH; hi/lo are valid from that point.
//   Outputs are registered. done=1 only in DONE. busy=1 only in RUN.
//   hi and lo hold their values until the next completion or reset.
//   Signed ops: operands are converted to magnitude before the loop.
//     Product sign = a[W-1]^b[W-1]; the 2W-bit product is negated if needed.
//     Quotient truncates toward zero. Remainder takes the sign of the dividend.
//     Signed ops use the same latency as unsigned ops.
//   Unsigned ops: no sign fix.
//   Overflow: -2^(W-1) / -1 gives lo=0x80000000, hi=0, dz=0. No trap.
//   Divide by zero (b==0, DIV or DIVU): still takes the full WIDTH cycles.
//     Result: hi=a, lo=all ones, dz=1. For MULT/MULTU with b==0, dz=0.
//   Operand inputs a, b and op may change freely after e0; only the latched copies are used.
// TESTING
//   1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//     done exactly 32 edges after start; busy high for 32 cycles.
//   2 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB(-21), dz=0.
//   3 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//     DIVU 7/2 -> lo=3 hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//   4 DIVU a=0x1234 b=0 -> hi=0x1234 lo=0xFFFFFFFF dz=1 after 32 cycles.
//     Following MULTU 2*3 -> lo=6, dz=0.
//   5 Launch DIV, pulse start again at cycle 5 -> ignored. Assert cancel at cycle 10 ->
//     busy=0 next edge, no done, hi/lo keep previous values. start+cancel in IDLE -> stays IDLE.
//   6 resetn low at cycle 15 of RUN, not aligned to a clock edge -> busy/done/hi/lo/dz = 0
//     immediately. After release, a new MULTU 5*5 -> lo=25 in 32 cycles.
//     Also: back-to-back start held during DONE -> second op completes 32 cycles later.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the HI/LO datapath.
// It runs one radix-2 iteration per clock, so an op takes WIDTH cycles.
// Multiply uses a shift-add loop. Divide uses a restoring loop.
// Both loops work on operand magnitudes, and the sign is fixed on the final edge.
// Ports:
//   i_clock, i_resetn   clock, async active-low reset
//   i_start, i_cancel   launch request / flush (cancel wins)
//   i_op                00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_a, i_b            multiplicand/dividend, multiplier/divisor
//   o_busy              high in RUN (pipeline stall)
//   o_done              one-cycle pulse when o_hi/o_lo update
//   o_dz                last completed op was a divide by zero
//   o_hi, o_lo          product high/low, or remainder/quotient
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic             i_cancel,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_div;    // latched op is a divide
  logic             r_neg_q;  // negate product / quotient
  logic             r_neg_r;  // negate remainder (dividend sign)
  logic             r_bz;     // divisor was zero
  logic [WIDTH-1:0] r_acc;    // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;     // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] r_b;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_hi, r_lo_out;
  logic             r_dz;

  // Operand magnitudes at launch. Unsigned ops (op[0]=1) never negate.
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_neg = ~i_op[0] & i_a[WIDTH-1];
  assign w_b_neg = ~i_op[0] & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // One iteration of either loop.
  logic [WIDTH:0]   w_sum, w_shl, w_diff;
  logic [WIDTH-1:0] w_acc_nxt, w_lo_nxt;
  assign w_sum  = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_b : '0)};
  assign w_shl  = {r_acc, r_lo[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, r_b};

  always_comb begin
    w_acc_nxt = r_acc;
    w_lo_nxt  = r_lo;
    if (r_div) begin
      // The shifted remainder is always below 2*divisor, so the restored or
      // subtracted value fits in WIDTH bits.
      if (!w_diff[WIDTH]) begin
        w_acc_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt  = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shl[WIDTH-1:0];
        w_lo_nxt  = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Add, then shift the {acc, lo} pair right by one. The carry enters acc[W-1].
      w_acc_nxt = w_sum[WIDTH:1];
      w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the value the last iteration produces.
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
  assign w_prod     = {w_acc_nxt, w_lo_nxt};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  // Divide by zero: the loop leaves |a| as the remainder, and the dividend
  // sign restores a. The quotient is forced to all ones regardless of sign.
  assign w_quo_fix  = r_bz ? '1 : (r_neg_q ? -w_lo_nxt : w_lo_nxt);
  assign w_rem_fix  = r_neg_r ? -w_acc_nxt : w_acc_nxt;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo_out <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_nxt;
            r_lo    <= w_lo_nxt;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state <= S_DONE;
              r_dz    <= r_div & r_bz;
              if (r_div) begin
                r_hi     <= w_rem_fix;
                r_lo_out <= w_quo_fix;
              end else begin
                r_hi     <= w_prod_fix[2*WIDTH-1:WIDTH];
                r_lo_out <= w_prod_fix[WIDTH-1:0];
              end
            end
          end
        end
        default: begin  // IDLE and DONE both accept a new launch
          if (i_start && !i_cancel) begin
            r_state <= S_RUN;
            r_count <= CW'(WIDTH);
            r_div   <= i_op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bz    <= i_op[1] & (i_b == '0);
            r_acc   <= '0;
            r_lo    <= w_a_mag;
            r_b     <= w_b_mag;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);
  assign o_dz   = r_dz;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32).
// Expected results are queued when an op is launched.
// A monitor pops and compares an entry on every done pulse.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         gclk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clock(gclk), .i_resetn(rstn), .i_start(start), .i_cancel(cancel),
    .i_op(op), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_dz(dz), .o_hi(hi), .o_lo(lo)
  );

  always #5 gclk = ~gclk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  res_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built from native 64-bit arithmetic.
  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    longint      sx, sy, q, m;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (o)
      2'd0: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin p = {32'b0, x} * {32'b0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (y == 0) begin
          r.hi = x; r.lo = '1; r.dz = 1'b1;
        end else if (o == 2'd2) begin
          q = sx / sy; m = sx % sy;
          r.lo = 32'(q); r.hi = 32'(m);
        end else begin
          r.lo = x / y; r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge gclk) begin
    if (rstn && done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        res_t e;
        e = sbq.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("dz", 32'(dz), 32'(e.dz));
      end
    end
  end

  // Drive a launch at the current negedge, then release start one cycle later.
  task automatic issue_now(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input bit push, input res_t e);
    op = o; a = x; b = y; start = 1'b1;
    if (push) sbq.push_back(e);
    @(negedge gclk);
    start = 1'b0;
    // Scramble the operands to confirm that the unit uses only its latched copies.
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input res_t e);
    @(negedge gclk);
    issue_now(o, x, y, push, e);
  endtask

  // Called one negedge after the launch edge. It expects done WIDTH negedges later.
  task automatic wait_done(input string tag, input bit post);
    int cyc = 0;
    int bcnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy) bcnt++;
      @(negedge gclk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd32);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd32);
    if (post) begin
      @(negedge gclk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input res_t e);
    issue(o, x, y, 1'b1, e);
    wait_done(tag, 1'b1);
  endtask

  initial begin
    int   cyc;
    res_t e;

    // Reset state
    repeat (3) @(negedge gclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rstn = 1'b1;

    // Directed vectors
    run("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{hi:32'hFFFF_FFFE, lo:32'h1, dz:1'b0});
    run("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, '{hi:32'hFFFF_FFFF, lo:32'hFFFF_FFEB, dz:1'b0});
    run("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, '{hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFD, dz:1'b0});
    run("divu_7_2", 2'd3, 32'd7, 32'd2, '{hi:32'd1, lo:32'd3, dz:1'b0});
    run("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, '{hi:32'd0, lo:32'h8000_0000, dz:1'b0});
    run("div_neg_dz", 2'd2, 32'hFFFF_FFF9, 32'd0, '{hi:32'hFFFF_FFF9, lo:32'hFFFF_FFFF, dz:1'b1});
    run("mult_b0", 2'd0, 32'h1234_5678, 32'd0, '{hi:32'd0, lo:32'd0, dz:1'b0});
    run("divu_dz", 2'd3, 32'h1234, 32'd0, '{hi:32'h1234, lo:32'hFFFF_FFFF, dz:1'b1});
    repeat (5) @(negedge gclk);
    chk("dz_held", 32'(dz), 32'd1);
    run("multu_2_3", 2'd1, 32'd2, 32'd3, '{hi:32'd0, lo:32'd6, dz:1'b0});

    // Random ops checked against the model
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      if (i % 3 == 0) ra = -ra;
      run("rand", ro, ra, rb, model(ro, ra, rb));
    end

    // A start pulse while RUN is active is ignored: the first op finishes on schedule.
    issue(2'd1, 32'd9, 32'd9, 1'b1, '{hi:32'd0, lo:32'd81, dz:1'b0});
    repeat (4) @(negedge gclk);
    op = 2'd1; a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    cyc = 5;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge gclk);
      cyc++;
    end
    chk("restart_ignored_latency", 32'(cyc), 32'd32);
    @(negedge gclk);
    chk("restart_ignored_idle", 32'(busy), 32'd0);

    // Cancel at cycle 10: no done pulse, and hi/lo/dz keep their values (0, 81, 0).
    issue(2'd2, 32'd100, 32'd7, 1'b0, '0);
    repeat (9) @(negedge gclk);
    cancel = 1'b1;
    @(negedge gclk);
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_done", 32'(done), 32'd0);
    chk("cancel_hi", hi, 32'd0);
    chk("cancel_lo", lo, 32'd81);
    chk("cancel_dz", 32'(dz), 32'd0);
    repeat (40) @(negedge gclk);
    chk("cancel_still_idle", 32'(busy), 32'd0);

    // start together with cancel in IDLE does not launch.
    start = 1'b1; cancel = 1'b1;
    @(negedge gclk);
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge gclk);

    // Async reset in the middle of RUN. Set dz/hi first so that the clear is visible.
    run("divu_dz2", 2'd3, 32'h55, 32'd0, '{hi:32'h55, lo:32'hFFFF_FFFF, dz:1'b1});
    issue(2'd1, 32'd5, 32'd5, 1'b0, '0);
    repeat (14) @(negedge gclk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_dz", 32'(dz), 32'd0);
    repeat (2) @(negedge gclk);
    #3 rstn = 1'b1;
    run("multu_5_5", 2'd1, 32'd5, 32'd5, '{hi:32'd0, lo:32'd25, dz:1'b0});

    // Back-to-back: start held during DONE launches the next op.
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{hi:32'd0, lo:32'd1, dz:1'b0});
    wait_done("b2b_first", 1'b0);
    issue_now(2'd3, 32'd100, 32'd9, 1'b1, '{hi:32'd1, lo:32'd11, dz:1'b0});
    wait_done("b2b_second", 1'b1);

    repeat (3) @(negedge gclk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
